// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the byte-stream handshake and the instruction-memory write port used
// by imem_loader.
//   byte_valid / byte_data : byte source -> loader
//   byte_ready             : loader -> byte source (byte taken on valid&&ready)
//   wr_en / wr_addr / wr_data : loader -> instruction memory write port
// Modports:
//   master : environment side (drives the stream, observes ready and writes)
//   slave  : loader side (consumes the stream, drives the memory write port)
// -----------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic                     byte_valid;
    logic [7:0]               byte_data;
    logic                     byte_ready;
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a program image as a byte stream and writes it into instruction
// memory as 32-bit little-endian words, holding the CPU in reset until a
// complete image has been written.
//
// Stream: 2-byte little-endian word count N, then N*4 data bytes (LSB first).
// With IMEM_LOADER_CHECKSUM_EN defined, one trailer byte follows the data and
// must equal the XOR of all data bytes (0x00 when N == 0).
//
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   start        : one-cycle pulse, begins a load from IDLE, DONE or ERR
//   bus          : imem_loader_if.slave (byte handshake + memory write port)
//   cpu_rst      : active-high CPU reset, low only in DONE
//   busy         : load in progress
//   done         : image loaded successfully (held)
//   error        : length overflow or checksum failure (held)
//   words_loaded : words written in the current or last load
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              WORD_COUNT    = 256,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    imem_loader_if.slave      bus,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_ERR   = 3'd6,
        ST_CSUM  = 3'd7
`else
        ST_ERR   = 3'd6
`endif
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] WORD_STRIDE = ADDRESS_WIDTH'(4);

    state_t                   state_r;
    state_t                   next_state_s;
    state_t                   final_state_s;   // where the load goes once all words are in
    logic                     accept_s;
    logic [15:0]              n_full_s;
    logic [7:0]               len_lo_r;
    logic [15:0]              len_r;
    logic [1:0]               byte_cnt_r;
    logic [23:0]              word_r;
    logic [ADDRESS_WIDTH-1:0] next_addr_r;
    logic                     wr_en_r;
    logic [ADDRESS_WIDTH-1:0] wr_addr_r;
    logic [DATA_WIDTH-1:0]    wr_data_r;
    logic [15:0]              words_r;
    logic                     byte_ready_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     error_r;
    logic                     cpu_rst_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]               csum_r;
`endif

    // States in which a stream byte can be taken.
    function automatic logic takes_bytes(input state_t s);
`ifdef IMEM_LOADER_CHECKSUM_EN
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
`else
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA);
`endif
    endfunction

    // States that make up an active load (CSUM is a trailer check, not a load).
    function automatic logic is_busy(input state_t s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_WRITE);
    endfunction

    // byte_ready_r mirrors the current state, so this is the true handshake.
    assign accept_s = bus.byte_valid & byte_ready_r;
    assign n_full_s = {bus.byte_data, len_lo_r};

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign final_state_s = ST_CSUM;
`else
    assign final_state_s = ST_DONE;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    next_state_s = ST_LEN0;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_LEN0: begin
                if (accept_s) begin
                    next_state_s = ST_LEN1;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_LEN1: begin
                if (!accept_s) begin
                    next_state_s = state_r;
                end else if (n_full_s == 16'd0) begin
                    next_state_s = final_state_s;
                end else if ({16'd0, n_full_s} > 32'(WORD_COUNT)) begin
                    next_state_s = ST_ERR;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept_s && (byte_cnt_r == 2'd3)) begin
                    next_state_s = ST_WRITE;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_WRITE: begin
                // words_r was already advanced on entry to WRITE.
                if (words_r == len_r) begin
                    next_state_s = final_state_s;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (!accept_s) begin
                    next_state_s = state_r;
                end else if (bus.byte_data == csum_r) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_ERR;
                end
            end
`endif
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Status outputs, registered from the next state so they track state_r.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            cpu_rst_r    <= 1'b1;
        end else begin
            byte_ready_r <= takes_bytes(next_state_s);
            busy_r       <= is_busy(next_state_s);
            done_r       <= (next_state_s == ST_DONE);
            error_r      <= (next_state_s == ST_ERR);
            cpu_rst_r    <= (next_state_s != ST_DONE);
        end
    end

    // Header capture, word assembly and memory write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_lo_r    <= 8'd0;
            len_r       <= 16'd0;
            byte_cnt_r  <= 2'd0;
            word_r      <= 24'd0;
            next_addr_r <= BASE_ADDR;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
            words_r     <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r      <= 8'd0;
`endif
        end else begin
            wr_en_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        byte_cnt_r  <= 2'd0;
                        next_addr_r <= BASE_ADDR;
                        words_r     <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r      <= 8'd0;
`endif
                    end
                end
                ST_LEN0: begin
                    if (accept_s) begin
                        len_lo_r <= bus.byte_data;
                    end
                end
                ST_LEN1: begin
                    if (accept_s) begin
                        len_r <= n_full_s;
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r     <= csum_r ^ bus.byte_data;
`endif
                        if (byte_cnt_r == 2'd3) begin
                            // Fourth byte completes the word: write it next cycle.
                            wr_en_r     <= 1'b1;
                            wr_addr_r   <= next_addr_r;
                            wr_data_r   <= DATA_WIDTH'({bus.byte_data, word_r});
                            next_addr_r <= next_addr_r + WORD_STRIDE;
                            words_r     <= words_r + 16'd1;
                        end else begin
                            // LSB arrives first, so shift new bytes in from the top.
                            word_r <= {bus.byte_data, word_r[23:8]};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_r;
    assign bus.wr_en      = wr_en_r;
    assign bus.wr_addr    = wr_addr_r;
    assign bus.wr_data    = wr_data_r;
    assign cpu_rst        = cpu_rst_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign error          = error_r;
    assign words_loaded   = words_r;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Table-driven bench for imem_loader: each record is a byte stream plus the
// writes and final status it must produce. Hand-written sequences cover reset
// behaviour, a mid-load reset and the maximum-length (WORD_COUNT) image.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    imem_loader_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    imem_loader #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .WORD_COUNT   (256),
        .BASE_ADDR    (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor, sampled on the falling edge.
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    logic        wr_q[$];
    always @(negedge clk) begin
        if (rst && bus.wr_en) begin
            wa_q.push_back(bus.wr_addr);
            wd_q.push_back(bus.wr_data);
            wc_q.push_back(cyc);
            wr_q.push_back(bus.byte_ready);
        end
    end

    int checks = 0;
    int errors = 0;
    bit stalled = 1'b0;
    int acc4_q[$];

    typedef struct {
        logic [79:0] stream;      // first byte in the top 8 bits
        int          nbytes;
        int          gap;
        bit          mid_start;
        logic [7:0]  trailer;
        bit          send_trailer;
        int          exp_nwr;
        logic [31:0] exp_a0;
        logic [31:0] exp_d0;
        logic [31:0] exp_a1;
        logic [31:0] exp_d1;
        bit          exp_done;
        bit          exp_err;
        logic [15:0] exp_words;
    } vec_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int NV = 7;
`else
    localparam int NV = 5;
`endif
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); wr_q.delete(); acc4_q.delete();
    endtask

    // Called at a falling edge; leaves the bench at the falling edge after the pulse.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte and hold it until taken; optionally pulse start in the gap after it.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit gap_start, output int acc);
        int t;
        acc = -1;
        if (stalled) return;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        t = 0;
        while (!bus.byte_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            stalled = 1'b1;
            bus.byte_valid = 1'b0;
            check("byte_ready_timeout", 64'd1, 64'd0);
            return;
        end
        @(negedge clk);
        acc = cyc;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        for (int g = 0; g < gap; g++) begin
            start = (gap_start && g == 0);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_after_start();
        check("start_error",  64'(error),        64'd0);
        check("start_done",   64'(done),         64'd0);
        check("start_ready",  64'(bus.byte_ready), 64'd1);
        check("start_busy",   64'(busy),         64'd1);
        check("start_cpurst", 64'(cpu_rst),      64'd1);
        check("start_words",  64'(words_loaded), 64'd0);
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        int   acc;
        v = vecs[k];
        clear_mon();
        pulse_start();
        check_after_start();
        for (int i = 0; i < v.nbytes; i++) begin
            send_byte(v.stream[79 - 8*i -: 8], v.gap, v.mid_start && (i == 5), acc);
            if (i >= 2 && ((i - 2) % 4) == 3) acc4_q.push_back(acc);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (v.send_trailer) send_byte(v.trailer, 0, 1'b0, acc);
`endif
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_done", k),   64'(done),         64'(v.exp_done));
        check($sformatf("v%0d_error", k),  64'(error),        64'(v.exp_err));
        check($sformatf("v%0d_cpurst", k), 64'(cpu_rst),      64'(!v.exp_done));
        check($sformatf("v%0d_busy", k),   64'(busy),         64'd0);
        check($sformatf("v%0d_words", k),  64'(words_loaded), 64'(v.exp_words));
        check($sformatf("v%0d_nwr", k),    64'(wa_q.size()),  64'(v.exp_nwr));
        for (int j = 0; j < wa_q.size() && j < v.exp_nwr; j++) begin
            check($sformatf("v%0d_addr%0d", k, j), 64'(wa_q[j]), 64'(j == 0 ? v.exp_a0 : v.exp_a1));
            check($sformatf("v%0d_data%0d", k, j), 64'(wd_q[j]), 64'(j == 0 ? v.exp_d0 : v.exp_d1));
            check($sformatf("v%0d_rdy%0d", k, j),  64'(wr_q[j]), 64'd0);
            if (j < acc4_q.size())
                check($sformatf("v%0d_lat%0d", k, j), 64'(wc_q[j]), 64'(acc4_q[j]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        logic [7:0]  xr;
        logic [31:0] w;

        //            stream                                nb gap mid trl  st nwr a0     d0             a1     d1             dn er words
        vecs[0] = '{80'h0200_1305_A000_9305_1000,            10, 0, 0, 8'h30, 1, 2, 32'h0, 32'h00A00513, 32'h4, 32'h00100593, 1, 0, 16'd2};
        vecs[1] = '{80'h0200_1305_A000_9305_1000,            10, 2, 1, 8'h30, 1, 2, 32'h0, 32'h00A00513, 32'h4, 32'h00100593, 1, 0, 16'd2};
        vecs[2] = '{{16'h0000, 64'h0},                        2, 0, 0, 8'h00, 1, 0, 32'h0, 32'h0,        32'h0, 32'h0,        1, 0, 16'd0};
        vecs[3] = '{{16'h0101, 64'h0},                        2, 0, 0, 8'h00, 0, 0, 32'h0, 32'h0,        32'h0, 32'h0,        0, 1, 16'd0};
        vecs[4] = '{{48'h0100_EFBE_ADDE, 32'h0},              6, 1, 0, 8'h22, 1, 1, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0,        1, 0, 16'd1};
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs[5] = '{{48'h0100_1305_A000, 32'h0},              6, 0, 0, 8'hB6, 1, 1, 32'h0, 32'h00A00513, 32'h0, 32'h0,        1, 0, 16'd1};
        vecs[6] = '{{48'h0100_1305_A000, 32'h0},              6, 0, 0, 8'hB7, 1, 1, 32'h0, 32'h00A00513, 32'h0, 32'h0,        0, 1, 16'd1};
`endif

        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        // Reset values while rst is held low.
        repeat (3) @(negedge clk);
        check("rst_ready",  64'(bus.byte_ready), 64'd0);
        check("rst_wren",   64'(bus.wr_en),      64'd0);
        check("rst_addr",   64'(bus.wr_addr),    64'd0);
        check("rst_data",   64'(bus.wr_data),    64'd0);
        check("rst_cpurst", 64'(cpu_rst),        64'd1);
        check("rst_busy",   64'(busy),           64'd0);
        check("rst_done",   64'(done),           64'd0);
        check("rst_error",  64'(error),          64'd0);
        check("rst_words",  64'(words_loaded),   64'd0);

        // Out of reset without start: nothing moves.
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("idle_cpurst", 64'(cpu_rst),        64'd1);
        check("idle_ready",  64'(bus.byte_ready), 64'd0);
        check("idle_wren",   64'(bus.wr_en),      64'd0);
        check("idle_done",   64'(done),           64'd0);
        check("idle_nwr",    64'(wa_q.size()),    64'd0);

        for (int k = 0; k < NV; k++) run_vec(k);

        // Reset after six data bytes, then a clean reload.
        clear_mon();
        pulse_start();
        begin
            logic [63:0] part;
            part = 64'h0200_1305_A000_9305;
            for (int i = 0; i < 8; i++) send_byte(part[63 - 8*i -: 8], 0, 1'b0, acc);
        end
        rst = 1'b0;
        #1;
        check("mrst_ready",  64'(bus.byte_ready), 64'd0);
        check("mrst_wren",   64'(bus.wr_en),      64'd0);
        check("mrst_addr",   64'(bus.wr_addr),    64'd0);
        check("mrst_data",   64'(bus.wr_data),    64'd0);
        check("mrst_cpurst", 64'(cpu_rst),        64'd1);
        check("mrst_busy",   64'(busy),           64'd0);
        check("mrst_done",   64'(done),           64'd0);
        check("mrst_error",  64'(error),          64'd0);
        check("mrst_words",  64'(words_loaded),   64'd0);
        check("mrst_nwr",    64'(wa_q.size()),    64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_vec(0);

        // Maximum-length image: N == WORD_COUNT is accepted.
        clear_mon();
        pulse_start();
        send_byte(8'h00, 0, 1'b0, acc);
        send_byte(8'h01, 0, 1'b0, acc);
        xr = 8'h00;
        for (int i = 0; i < 256; i++) begin
            w = {16'hC0DE, 16'(i)};
            for (int b = 0; b < 4; b++) begin
                send_byte(w[8*b +: 8], 0, 1'b0, acc);
                xr = xr ^ w[8*b +: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(xr, 0, 1'b0, acc);
`endif
        repeat (3) @(negedge clk);
        check("max_nwr",   64'(wa_q.size()),  64'd256);
        check("max_done",  64'(done),         64'd1);
        check("max_error", 64'(error),        64'd0);
        check("max_words", 64'(words_loaded), 64'd256);
        for (int j = 0; j < wa_q.size() && j < 256; j++) begin
            check($sformatf("max_addr%0d", j), 64'(wa_q[j]), 64'(32'(4 * j)));
            check($sformatf("max_data%0d", j), 64'(wd_q[j]), 64'({16'hC0DE, 16'(j)}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-fetch path: takes a byte stream over a valid/ready handshake and writes packed 32-bit little-endian words into instruction memory.
- The fetch stage is the reader of that memory; this block fills it.
- Holds the CPU in reset until a complete, valid program image has been written.
- Sits between the external byte source (UART/bench) and the instruction memory write port.

Parameters:
- ADDRESS_WIDTH, 32, width of wr_addr
- DATA_WIDTH, 32, width of wr_data; fixed at 32 (4 bytes per word)
- WORD_COUNT, 256, max program length in words
- BASE_ADDR, 0, byte address of the first word written

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-low (0 = reset)
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
- byte_valid  input  1  source has a byte on byte_data
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts byte_data this cycle
- wr_en  output  1  instruction memory write strobe
- wr_addr  output  ADDRESS_WIDTH  byte address of the word written
- wr_data  output  DATA_WIDTH  word written
- cpu_rst  output  1  active-high reset to the CPU
- busy  output  1  load in progress
- done  output  1  image loaded successfully; level, held
- error  output  1  length overflow or checksum failure; level, held
- words_loaded  output  16  words written in the current or last load

Behaviour:
- Transfer: a byte is accepted on a rising clk when byte_valid && byte_ready. byte_data is ignored otherwise.
- Stream format:
  - 2-byte header: word count N, little-endian (low byte first).
  - Then N*4 data bytes; each word is sent LSB first.
- FSM states: IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR.
  - IDLE: start -> LEN0.
  - LEN0: accepts the low byte of N -> LEN1.
  - LEN1: accepts the high byte of N.
    - N == 0 -> DONE.
    - N > WORD_COUNT -> ERR.
    - Otherwise -> DATA.
  - DATA: accepts bytes into a 4-byte shift register; the 4th byte -> WRITE.
  - WRITE: exactly one cycle.
    - wr_en=1, wr_addr = BASE_ADDR + 4*idx, wr_data = assembled word.
    - idx increments; words_loaded = idx+1.
    - If idx+1 == N -> DONE, else -> DATA.
  - DONE: done=1, cpu_rst=0. start -> LEN0 (reload); this clears done and words_loaded and sets cpu_rst=1.
  - ERR: error=1, cpu_rst=1. start -> LEN0 and clears error.
- byte_ready = 1 only in LEN0, LEN1 and DATA; it is 0 in WRITE, so the stream stalls for one cycle per word.
- Minimum latency: 4th byte accepted at edge k -> wr_en high in cycle k+1.
- busy = 1 in LEN0, LEN1, DATA and WRITE.
- start is ignored while busy=1.
- wr_en, wr_addr and wr_data are registered. wr_addr and wr_data hold their last value when wr_en=0.
- Address arithmetic: ADDRESS_WIDTH bits, wraps modulo 2^ADDRESS_WIDTH (no check).
- Reset (rst=0, async), applies at any time including mid-load:
  - State -> IDLE.
  - Outputs: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_rst=1, busy=0, done=0, error=0, words_loaded=0.
  - Partial words already written stay in memory.
- cpu_rst is 1 in every state except DONE.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word (N>0), one trailer byte is expected, equal to the XOR of all data bytes.
  - New state CSUM; byte_ready=1 in CSUM.
  - WRITE of the last word -> CSUM.
  - Trailer match -> DONE; mismatch -> ERR.
  - For N == 0 the trailer must be 0x00.
  - Words are still written before the check, so a mismatch leaves memory written but holds the CPU in reset.
- Undefined: no trailer byte is expected; the final WRITE goes directly to DONE.

Test Plan:
- Reset, no start -> cpu_rst=1, byte_ready=0, wr_en=0, done=0 indefinitely.
- start, stream 02 00 13 05 A0 00 93 05 10 00 with valid held high ->
  - wr_en pulse 1: addr 0x0, data 0x00A00513.
  - wr_en pulse 2: addr 0x4, data 0x00100593.
  - Each pulse is one cycle after its 4th byte, with byte_ready low that cycle.
  - Then done=1, cpu_rst=0, words_loaded=2.
- Header N=0x0101 (257) with WORD_COUNT=256 -> no wr_en, error=1, cpu_rst=1; start again -> error clears, byte_ready=1.
- Gaps in byte_valid and start pulsed mid-load -> identical writes to the gap-free case; the mid-load start has no effect.
- rst low after 6 data bytes -> immediate IDLE with all outputs at reset values. A fresh start plus a full stream then loads correctly from BASE_ADDR.
- With IMEM_LOADER_CHECKSUM_EN: 01 00 13 05 A0 00 then trailer B6 -> done=1; trailer B7 -> error=1, cpu_rst=1, one write still observed.
